score_display: RTL and testbench
================================

# score_display

Downstream stage of the catch-the-light game. Takes the binary score produced by the game logic and converts it to four BCD digits with a serial double-dabble converter. Drives the board's 4-digit multiplexed 7-segment display, scanning one digit at a time. All outputs are registered; the displayed value changes atomically, only after a conversion completes.

## Interface
- DIGIT_CYCLES, 5000: clk cycles each digit is lit per scan step.
- BLANK_LEADING, 0: when 1, leading zero digits (thousands, hundreds, tens) are blanked; the ones digit is never blanked.

- clk  in  1  board clock.
- reset_n  in  1  reset. One clock; reset is synchronous and active-low.
- score_in  in  14  binary score, unsigned; sampled only when score_valid=1.
- score_valid  in  1  one-cycle strobe: new score available.
- busy  out  1  conversion in progress.
- Anode_Activate  out  4  digit enables, active-low; [3]=thousands … [0]=ones.
- LED_out  out  7  segments, active-low, [6]=a … [0]=g ("0" = 7'b0000001).

## Operation
- Saturation: score_in > 9999 is converted as 9999.
- FSM states:
  - IDLE: on score_valid, latch the saturated score and go to SHIFT.
  - SHIFT: 14 iterations, one per cycle. Each iteration adds 3 to every BCD nibble ≥5, then shifts left by one, bringing in the binary MSB.
  - COMMIT: one cycle; writes the result into the display register disp_bcd[15:0].
- Exit from COMMIT:
  - pending=1: load the pending value, clear pending, go to SHIFT with no IDLE cycle.
  - pending=0: go to IDLE.
- Pending capture: score_valid while in SHIFT or COMMIT stores the value in a pending register and sets pending. Last write wins. Intermediate values are never displayed.
- Scan:
  - refresh_cnt counts 0..DIGIT_CYCLES-1, then wraps.
  - At the wrap, scan_idx advances 0→1→2→3→0.
- Anode by scan_idx:
  - 0 → 4'b0111 (thousands)
  - 1 → 4'b1011 (hundreds)
  - 2 → 4'b1101 (tens)
  - 3 → 4'b1110 (ones)
- Segment patterns:
  - 0: 0000001
  - 1: 1001111
  - 2: 0010010
  - 3: 0000110
  - 4: 1001100
  - 5: 0100100
  - 6: 0100000
  - 7: 0001111
  - 8: 0000000
  - 9: 0000100
  - blank: 1111111
  - any non-BCD nibble: blank.
- BLANK_LEADING=1: a digit is blanked iff it and every higher digit are zero.

## Timing
- Reset values:
  - Anode_Activate = 4'b0111, LED_out = 7'b0000001, busy = 0.
  - disp_bcd = 0000, scan_idx = 0, refresh_cnt = 0, pending = 0, state = IDLE.
- Reset mid-conversion aborts the conversion, drops any pending value, and shows 0000.
- Conversion latency: score_valid sampled at edge N in IDLE.
  - busy is high for cycles N+1 … N+15 (14 SHIFT + 1 COMMIT).
  - disp_bcd holds the new value from N+16.
  - Anode_Activate/LED_out are registered from (scan_idx, disp_bcd) with one cycle of latency.
  - A new value therefore reaches LED_out at N+17 if that digit is selected.
- score_valid in IDLE on the same edge reset_n is deasserted is ignored, because reset has priority.
- A pending value with back-to-back restart makes busy stay high continuously: 15 more cycles per queued conversion.
- Scan timing:
  - Each anode is low for exactly DIGIT_CYCLES cycles.
  - Exactly one anode is low at any time.
  - The scan is never disturbed by conversions.

## Structure
- Package score_display_pkg holds:
  - state enum {IDLE, SHIFT, COMMIT};
  - SEG_DIGIT[0:9] and SEG_BLANK constants;
  - ANODE_SEL[0:3] constants;
  - MAX_SCORE = 9999 and SCORE_W = 14.
- Sub-module bin2bcd_serial contains the double-dabble datapath and the 14-step counter. It has start/done handshakes and a 16-bit BCD output.
- The top level contains saturation, the pending register, disp_bcd, the scan counter and the segment decode.

## Test plan
- Reset: hold reset_n=0 for 3 cycles → Anode_Activate=0111, LED_out=0000001, busy=0; all four digits decode "0" over a full scan.
- score_in=25, one valid pulse → busy high exactly 15 cycles; digits 0,0,2,5; tens digit LED_out=0010010 under anode 1101.
- score_in=1175 → digits 1,1,7,5. score_in=12000 → digits 9,9,9,9 (saturation).
- Pending queue: valid(25), then valid(50) at busy cycle 3, then valid(75) at busy cycle 10 → busy stays high 30 cycles; display goes 0000 → 0025 → 0075, never 0050.
- Scan, DIGIT_CYCLES=4: anodes rotate 0111, 1011, 1101, 1110, 4 cycles each, wrap to 0111; with BLANK_LEADING=1 and score 50, the thousands and hundreds digits show 1111111 and the tens/ones digits show 5 and 0.
- Reset mid-conversion: reset_n=0 at busy cycle 7 of score 775 → next cycle busy=0 and disp_bcd=0000; after release, score 100 converts normally to 0100.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display slice.
//   state_e     : conversion control FSM states
//   SEG_DIGIT   : active-low 7-segment patterns for 0..9, [6]=a .. [0]=g
//   SEG_BLANK   : all segments off
//   ANODE_SEL   : active-low anode pattern per scan index (0=thousands .. 3=ones)
//   MAX_SCORE   : largest displayable score, larger inputs saturate to it
//   SCORE_W     : width of the binary score
package score_display_pkg;

  localparam int SCORE_W   = 14;
  localparam int MAX_SCORE = 9999;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_e;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] ANODE_SEL [0:3] = '{
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };

  // Non-BCD nibbles can only appear through corruption; show nothing for them.
  function automatic logic [6:0] seg_of(input logic [3:0] nib);
    if (nib > 4'd9) return SEG_BLANK;
    return SEG_DIGIT[nib];
  endfunction

  function automatic logic [SCORE_W-1:0] saturate(input logic [SCORE_W-1:0] s);
    if (s > SCORE_W'(MAX_SCORE)) return SCORE_W'(MAX_SCORE);
    return s;
  endfunction

endpackage

// File: rtl/score_display_bin2bcd_serial.sv
// Serial double-dabble converter: one add-3/shift iteration per clock.
//   clk, reset_n : clock, synchronous active-low reset
//   start        : load bin_in and begin a 14-step conversion (overrides any
//                  conversion in flight)
//   bin_in       : binary value, must be <= 9999 to fit four BCD digits
//   done         : high during the cycle whose edge performs the final step;
//                  bcd_out is valid from the following cycle until next start
//   bcd_out      : four BCD digits, [15:12]=thousands
module bin2bcd_serial
  import score_display_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin_in,
  output logic               done,
  output logic [15:0]        bcd_out
);

  logic [SCORE_W-1:0] bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [15:0]        bcd_adj;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    cnt_d = cnt_q;
    if (start) begin
      bin_d = bin_in;
      bcd_d = '0;
      cnt_d = 4'(SCORE_W);
    end else if (cnt_q != 4'd0) begin
      {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
      cnt_d          = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign done    = (cnt_q == 4'd1);
  assign bcd_out = bcd_q;

endmodule

// File: rtl/score_display.sv
// Score to 4-digit multiplexed 7-segment display.
//   clk            : board clock
//   reset_n        : synchronous active-low reset
//   score_in       : binary score, sampled when score_valid=1
//   score_valid    : one-cycle strobe
//   busy           : conversion in progress (registered)
//   Anode_Activate : active-low digit enables, [3]=thousands .. [0]=ones
//   LED_out        : active-low segments, [6]=a .. [0]=g
//
// state  | meaning
// IDLE   | waiting for score_valid
// SHIFT  | converter running its 14 steps
// COMMIT | result copied into disp_bcd; restart if a newer score is waiting
module score_display
  import score_display_pkg::*;
#(
  parameter int DIGIT_CYCLES  = 5000,
  parameter bit BLANK_LEADING = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [SCORE_W-1:0] score_in,
  input  logic               score_valid,
  output logic               busy,
  output logic [3:0]         Anode_Activate,
  output logic [6:0]         LED_out
);

  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

  state_e             state_q, state_d;
  logic               pend_q, pend_d;
  logic [SCORE_W-1:0] pend_val_q, pend_val_d;
  logic [15:0]        disp_bcd_q, disp_bcd_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   refresh_cnt_q, refresh_cnt_d;
  logic [1:0]         scan_idx_q, scan_idx_d;
  logic [3:0]         anode_q, anode_d;
  logic [6:0]         led_q, led_d;

  logic [SCORE_W-1:0] sat_in;
  logic               conv_start;
  logic [SCORE_W-1:0] conv_bin;
  logic               conv_done;
  logic [15:0]        conv_bcd;
  logic [3:0]         digit_nib;
  logic               lead_zero;

  assign sat_in = saturate(score_in);

  bin2bcd_serial u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (conv_start),
    .bin_in  (conv_bin),
    .done    (conv_done),
    .bcd_out (conv_bcd)
  );

  // A strobe arriving in COMMIT is newer than anything pending, so it is
  // started directly instead of being parked (last write wins).
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    disp_bcd_d = disp_bcd_q;
    conv_start = 1'b0;
    conv_bin   = sat_in;
    case (state_q)
      IDLE: begin
        if (score_valid) begin
          conv_start = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (score_valid) begin
          pend_d     = 1'b1;
          pend_val_d = sat_in;
        end
        if (conv_done) state_d = COMMIT;
      end
      COMMIT: begin
        disp_bcd_d = conv_bcd;
        if (score_valid) begin
          conv_start = 1'b1;
          pend_d     = 1'b0;
          state_d    = SHIFT;
        end else if (pend_q) begin
          conv_start = 1'b1;
          conv_bin   = pend_val_q;
          pend_d     = 1'b0;
          state_d    = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_comb begin
    refresh_cnt_d = refresh_cnt_q + CNT_W'(1);
    scan_idx_d    = scan_idx_q;
    if (refresh_cnt_q == CNT_W'(DIGIT_CYCLES - 1)) begin
      refresh_cnt_d = '0;
      scan_idx_d    = scan_idx_q + 2'd1;
    end
  end

  // lead_zero: this digit and every digit above it are zero.
  always_comb begin
    digit_nib = disp_bcd_q[3:0];
    lead_zero = 1'b0;
    case (scan_idx_q)
      2'd0: begin
        digit_nib = disp_bcd_q[15:12];
        lead_zero = (disp_bcd_q[15:12] == 4'd0);
      end
      2'd1: begin
        digit_nib = disp_bcd_q[11:8];
        lead_zero = (disp_bcd_q[15:8] == 8'd0);
      end
      2'd2: begin
        digit_nib = disp_bcd_q[7:4];
        lead_zero = (disp_bcd_q[15:4] == 12'd0);
      end
      default: begin
        digit_nib = disp_bcd_q[3:0];
        lead_zero = 1'b0;
      end
    endcase
    anode_d = ANODE_SEL[scan_idx_q];
    led_d   = (BLANK_LEADING && lead_zero) ? SEG_BLANK : seg_of(digit_nib);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      pend_q        <= 1'b0;
      pend_val_q    <= '0;
      disp_bcd_q    <= '0;
      busy_q        <= 1'b0;
      refresh_cnt_q <= '0;
      scan_idx_q    <= '0;
      anode_q       <= ANODE_SEL[0];
      led_q         <= SEG_DIGIT[0];
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      pend_val_q    <= pend_val_d;
      disp_bcd_q    <= disp_bcd_d;
      busy_q        <= busy_d;
      refresh_cnt_q <= refresh_cnt_d;
      scan_idx_q    <= scan_idx_d;
      anode_q       <= anode_d;
      led_q         <= led_d;
    end
  end

  assign busy           = busy_q;
  assign Anode_Activate = anode_q;
  assign LED_out        = led_q;

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;

  localparam int DC = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [13:0] score_in;
  logic        score_valid;
  logic        busy0, busy1;
  logic [3:0]  an0, an1;
  logic [6:0]  led0, led1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  score_display #(.DIGIT_CYCLES(DC), .BLANK_LEADING(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .score_in(score_in), .score_valid(score_valid),
    .busy(busy0), .Anode_Activate(an0), .LED_out(led0));

  score_display #(.DIGIT_CYCLES(DC), .BLANK_LEADING(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .score_in(score_in), .score_valid(score_valid),
    .busy(busy1), .Anode_Activate(an1), .LED_out(led1));

  // ---------------- reference model ----------------
  function automatic int sat(input int s);
    return (s > 9999) ? 9999 : s;
  endfunction

  function automatic int pow10(input int p);
    int r = 1;
    for (int i = 0; i < p; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] seg_ref(input int d);
    case (d)
      0: return 7'b0000001;  1: return 7'b1001111;  2: return 7'b0010010;
      3: return 7'b0000110;  4: return 7'b1001100;  5: return 7'b0100100;
      6: return 7'b0100000;  7: return 7'b0001111;  8: return 7'b0000000;
      9: return 7'b0000100;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] anode_ref(input int idx);
    case (idx)
      0: return 4'b0111;  1: return 4'b1011;  2: return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  function automatic int idx_of(input logic [3:0] an);
    for (int i = 0; i < 4; i++) if (an === anode_ref(i)) return i;
    return -1;
  endfunction

  // idx 0 = thousands .. 3 = ones
  function automatic logic [6:0] exp_seg(input int v, input int idx, input bit blank_en);
    int pos = 3 - idx;
    if (blank_en && pos > 0 && v < pow10(pos)) return 7'b1111111;
    return seg_ref((v / pow10(pos)) % 10);
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic scan_check(input string tag, input int v, input int n);
    int i0, i1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      i0 = idx_of(an0);
      i1 = idx_of(an1);
      check({tag, "_anode0_valid"}, 32'(i0 >= 0), 32'd1);
      check({tag, "_anode1_valid"}, 32'(i1 >= 0), 32'd1);
      if (i0 >= 0) check({tag, "_led"}, 32'(led0), 32'(exp_seg(v, i0, 1'b0)));
      if (i1 >= 0) check({tag, "_led_blank"}, 32'(led1), 32'(exp_seg(v, i1, 1'b1)));
    end
  endtask

  task automatic pulse(input int s);
    @(negedge clk);
    score_in    = 14'(s);
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
  endtask

  // Pulse, measure busy length, then verify the whole scan shows the new value.
  task automatic convert(input string tag, input int s);
    int n = 0;
    pulse(s);
    while (busy0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_len"}, 32'(n), 32'd15);
    @(negedge clk);
    scan_check(tag, sat(s), 4 * DC + 3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, i0, prev_idx, pos;
    bit seen25, ok;
    logic [3:0] prev_an;
    int allowed [3];

    reset_n     = 1'b0;
    score_in    = '0;
    score_valid = 1'b0;

    // reset held 3 cycles; a strobe on the last reset edge must be ignored
    repeat (2) @(negedge clk);
    score_in    = 14'd1234;
    score_valid = 1'b1;
    @(negedge clk);
    check("rst_anode", 32'(an0), 32'h7);
    check("rst_led", 32'(led0), 32'h01);
    check("rst_led_blank_inst", 32'(led1), 32'h01);
    check("rst_busy", 32'(busy0), 32'd0);
    reset_n     = 1'b1;
    score_valid = 1'b0;
    @(negedge clk);
    check("rst_valid_ignored", 32'(busy0), 32'd0);
    scan_check("rst_scan", 0, 4 * DC + 2);

    // scan rotation: exact dwell and wrap
    prev_an = an0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an0 === prev_an && n < 3 * DC);
    check("scan_change_seen", 32'(n < 3 * DC), 32'd1);
    prev_idx = idx_of(an0);
    if (prev_idx < 0) prev_idx = 0;
    for (int j = 0; j < 8 * DC; j++) begin
      if (j > 0) @(negedge clk);
      check("scan_rotate", 32'(an0), 32'(anode_ref((prev_idx + j / DC) % 4)));
    end

    // pending queue: 25, then 50 at busy cycle 3, then 75 at busy cycle 10
    allowed = '{0, 25, 75};
    seen25  = 1'b0;
    pulse(25);
    n = 0;
    while (busy0 && n < 200) begin
      n++;
      i0 = idx_of(an0);
      ok = 1'b0;
      if (i0 >= 0) foreach (allowed[a]) if (led0 === exp_seg(allowed[a], i0, 1'b0)) ok = 1'b1;
      check("queue_no_intermediate", 32'(ok), 32'd1);
      if (i0 == 2 && led0 === seg_ref(2)) seen25 = 1'b1;
      score_valid = 1'b0;
      if (n == 3) begin
        score_in = 14'd50; score_valid = 1'b1;
      end else if (n == 10) begin
        score_in = 14'd75; score_valid = 1'b1;
      end
      @(negedge clk);
    end
    score_valid = 1'b0;
    check("queue_busy_len", 32'(n), 32'd30);
    check("queue_saw_0025", 32'(seen25), 32'd1);
    @(negedge clk);
    scan_check("queue_final", 75, 4 * DC + 3);

    // directed values incl. saturation and leading-zero blanking
    convert("v25", 25);
    convert("v1175", 1175);
    convert("v12000", 12000);
    convert("v50", 50);
    convert("v9999", 9999);
    convert("v0", 0);
    convert("v16383", 16383);

    // random scores over the full input range
    for (int r = 0; r < 6; r++) convert("rand", int'($urandom_range(0, 16383)));

    // reset mid-conversion
    pulse(775);
    n = 1;
    while (busy0 && n < 7) begin
      n++;
      @(negedge clk);
    end
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_disp", 32'(dut0.disp_bcd_q), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_busy_after", 32'(busy0), 32'd0);
    scan_check("midrst_scan", 0, 4 * DC + 2);
    convert("v100", 100);

    pos = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
